// File: rtl/div_multicycle_param_if.sv
// Handshake and data bundle between the EX stage (master) and the iterative divider (slave).
interface div_multicycle_param_if #(
    parameter int WIDTH = 32
);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;
    logic               dbz_o;
    logic               ovf_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o, dbz_o, ovf_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o, dbz_o, ovf_o
    );
endinterface

// File: rtl/div_multicycle_param.sv
// Radix-2 restoring divider, signed/unsigned, result packed as {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to skip the leading-zero iterations of the dividend magnitude.
module div_multicycle_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    div_multicycle_param_if.slave bus
);
    typedef enum logic [2:0] {FREE, DBZ, ON, FIX, END} state_t;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_t             state, state_next;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   divisor;
    logic [CNT_W-1:0]   cnt;
    logic               q_neg, r_neg, dbz_flag, ovf_flag;
    logic [2*WIDTH-1:0] result;
    logic               ready, dbz, ovf;

    logic [WIDTH-1:0]   abs1, abs2, diff, quo_fix, rem_fix;
    logic [WIDTH:0]     trial;
    logic               fits, last_iter, ovf_case, go;
    logic [2*WIDTH-1:0] start_acc;
    logic [CNT_W-1:0]   start_cnt;

    always_comb begin
        abs1      = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
        abs2      = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
        // acc holds {partial remainder, dividend/quotient}; trial takes the next dividend bit
        trial     = acc[2*WIDTH-1:WIDTH-1];
        fits      = trial >= {1'b0, divisor};
        diff      = trial[WIDTH-1:0] - divisor;
        quo_fix   = q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        ovf_case  = bus.signed_div_i && (bus.opdata1_i == MIN_VAL) && (&bus.opdata2_i);
        last_iter = (cnt == LAST);
        go        = bus.start_i && !bus.annul_i;
    end

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] lz;

    // Leading zeros of |op1|, capped at WIDTH-1 so a zero dividend still runs one iteration
    always_comb begin
        lz = LAST;
        for (int i = 0; i < WIDTH; i++) begin
            if (abs1[i]) lz = CNT_W'(WIDTH - 1 - i);
        end
        start_acc = {{WIDTH{1'b0}}, abs1 << lz};
        start_cnt = lz;
    end
`else
    always_comb begin
        start_acc = {{WIDTH{1'b0}}, abs1};
        start_cnt = '0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FREE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FREE: begin
                if (go) begin
                    if (bus.opdata2_i == '0) state_next = DBZ;
                    else                     state_next = ON;
                end
            end
            DBZ: begin
                if (bus.annul_i) state_next = FREE;
                else             state_next = END;
            end
            ON: begin
                if (bus.annul_i)     state_next = FREE;
                else if (last_iter)  state_next = FIX;
            end
            FIX: begin
                if (bus.annul_i) state_next = FREE;
                else             state_next = END;
            end
            END: begin
                if (!bus.start_i) state_next = FREE;
            end
            default: state_next = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            divisor  <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dbz_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (go) begin
                        q_neg    <= bus.signed_div_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        r_neg    <= bus.signed_div_i && bus.opdata1_i[WIDTH-1];
                        dbz_flag <= (bus.opdata2_i == '0);
                        ovf_flag <= ovf_case;
                        divisor  <= abs2;
                        acc      <= start_acc;
                        cnt      <= start_cnt;
                    end
                end
                DBZ: acc <= {bus.opdata1_i, {WIDTH{1'b1}}};
                ON: begin
                    acc <= fits ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: acc <= {rem_fix, quo_fix};
                default: ;
            endcase
        end
    end

    // Visible outputs are only loaded while END is held, and drop on the edge that leaves it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            ready  <= 1'b0;
            dbz    <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == END && bus.start_i) begin
            result <= acc;
            ready  <= 1'b1;
            dbz    <= dbz_flag;
            ovf    <= ovf_flag;
        end else begin
            result <= '0;
            ready  <= 1'b0;
            dbz    <= 1'b0;
            ovf    <= 1'b0;
        end
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;
    assign bus.dbz_o    = dbz;
    assign bus.ovf_o    = ovf;
    assign bus.busy_o   = (state != FREE);
endmodule

// File: tb/tb_div_multicycle_param.sv
// Self-checking bench for div_multicycle_param at WIDTH=32: directed cases plus random
// operands compared against an arithmetic reference model.
module tb_div_multicycle_param;
    localparam int W      = 32;
    localparam int BUDGET = 2 * W + 10;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    div_multicycle_param_if #(.WIDTH(W)) bus ();

    div_multicycle_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Quotient/remainder from plain arithmetic; signed division truncates toward zero
    function automatic void refModel(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                     output logic [63:0] res, output logic dbz, output logic ovf,
                                     output int lat);
        longint sa, sb;
        logic [31:0] mag;
        int lz;
        dbz = 1'b0;
        ovf = 1'b0;
        lat = W + 2;
        if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
            dbz = 1'b1;
            lat = 2;
        end else if (sgn) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            res = {32'(sa % sb), 32'(sa / sb)};
            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end else begin
            res = {a % b, a / b};
        end
        mag = (sgn && a[31]) ? -a : a;
        lz  = 0;
        for (int i = 31; i >= 0 && !mag[i]; i--) lz++;
        if (lz > W - 1) lz = W - 1;
`ifdef DIV_EARLY_OUT_EN
        if (b != 32'd0) lat = (W - lz) + 2;
`else
        lz = 0;
`endif
    endfunction

    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] exp_res;
        logic        exp_dbz, exp_ovf;
        int          exp_lat, lat;
        refModel(sgn, a, b, exp_res, exp_dbz, exp_ovf, exp_lat);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("busy", bus.busy_o, 1);
        lat = 0;
        for (int n = 1; n <= BUDGET; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) begin
                lat = n;
                break;
            end
        end
        checkOutput("latency", lat, exp_lat);
        if (lat != 0) begin
            checkOutput("result", bus.result_o, exp_res);
            checkOutput("dbz", bus.dbz_o, exp_dbz);
            checkOutput("ovf", bus.ovf_o, exp_ovf);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                checkOutput("hold_ready", bus.ready_o, 1);
                checkOutput("hold_result", bus.result_o, exp_res);
            end
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("release_ready", bus.ready_o, 0);
        checkOutput("release_result", bus.result_o, 0);
        checkOutput("release_busy", bus.busy_o, 0);
    endtask

    initial begin
        logic        seen;
        logic        sgn;
        logic [31:0] a, b;

        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        checkOutput("reset_ready", bus.ready_o, 0);
        checkOutput("reset_result", bus.result_o, 0);
        checkOutput("reset_busy", bus.busy_o, 0);
        checkOutput("reset_flags", {bus.dbz_o, bus.ovf_o}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        applyStimulus(1'b0, 32'd100, 32'd7, 3);
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, 0);
        applyStimulus(1'b1, 32'd100, 32'hFFFF_FFF9, 0);
        applyStimulus(1'b0, 32'h1234_5678, 32'd0, 0);
        applyStimulus(1'b1, 32'h8765_4321, 32'd0, 1);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        applyStimulus(1'b0, 32'd5, 32'd2, 0);
        applyStimulus(1'b0, 32'd0, 32'd9, 0);

        // Abort on the tenth ON cycle; no result may ever appear
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            seen |= bus.ready_o;
        end
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("annul_busy", bus.busy_o, 0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        for (int n = 0; n < W + 4; n++) begin
            @(posedge clk);
            #1;
            seen |= bus.ready_o;
        end
        checkOutput("annul_ready", seen, 0);
        applyStimulus(1'b0, 32'd9, 32'd3, 0);

        // Asynchronous reset mid-iteration and while a result is being held
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.signed_div_i = 1'b0;
            bus.opdata1_i    = 32'd100;
            bus.opdata2_i    = 32'd7;
            bus.start_i      = 1'b1;
            repeat ((k == 0) ? 6 : W + 6) @(posedge clk);
            #1;
            checkOutput("pre_reset_busy", bus.busy_o, 1);
            checkOutput("pre_reset_ready", bus.ready_o, (k == 0) ? 0 : 1);
            #1 rst = 1'b0;
            #1;
            checkOutput("async_busy", bus.busy_o, 0);
            checkOutput("async_ready", bus.ready_o, 0);
            checkOutput("async_result", bus.result_o, 0);
            @(negedge clk);
            bus.start_i = 1'b0;
            rst = 1'b1;
        end

        for (int t = 0; t < 40; t++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1: begin
                    b = 32'hFFFF_FFFF;
                    if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
                end
                2:       b = 32'($urandom_range(1, 15));
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            applyStimulus(sgn, a, b, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_multicycle_param.md
Name: div_multicycle_param

Overview:
- Parametrised successor to the core's fixed 32-bit iterative divider.
- Radix-2 restoring divider, signed or unsigned, quotient and remainder packed into one result word.
- Adds:
  - generic WIDTH;
  - explicit divide-by-zero and signed-overflow flags;
  - a busy indication;
  - defined divide-by-zero results;
  - optional leading-zero early termination.
- Sits beside the EX stage; the EX stage stalls the pipeline until ready_o is asserted.

Parameters:
- WIDTH, 32, operand width in bits. Legal range: 8..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width. Derived; do not override.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous reset, active-low (0 = reset).
- signed_div_i  in  1  1 = two's-complement operands; 0 = unsigned.
- opdata1_i  in  WIDTH  Dividend. Must stay stable from start until ready_o.
- opdata2_i  in  WIDTH  Divisor. Must stay stable from start until ready_o.
- start_i  in  1  1 = request/hold operation; 0 = release result.
- annul_i  in  1  1 = abort (pipeline flush).
- result_o  out  2*WIDTH  {remainder, quotient}.
- ready_o  out  1  Result valid.
- busy_o  out  1  High in every state except FREE.
- dbz_o  out  1  Divide-by-zero; valid while ready_o=1.
- ovf_o  out  1  Signed MIN / -1; valid while ready_o=1.

Behaviour:
- Reset (rst low, asynchronous):
  - State=FREE.
  - result_o=0, ready_o=0, dbz_o=0, ovf_o=0.
  - Internal dividend, divisor and counter cleared.
  - Reset mid-operation discards all work.
- States: FREE, DBZ, ON, FIX, END.
- FREE:
  - start_i=1, annul_i=0, opdata2_i=0 -> DBZ.
  - start_i=1, annul_i=0, opdata2_i!=0 -> ON:
    - latch |op1| and |op2|; absolute value is taken only when signed_div_i=1 and the MSB is set;
    - counter=0;
    - latch sign of quotient (op1 MSB ^ op2 MSB, signed only) and sign of remainder (op1 MSB, signed only).
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- DBZ: one cycle, then -> END.
  - Quotient = all ones.
  - Remainder = opdata1_i unmodified.
  - dbz_o=1.
- ON: one iteration per cycle.
  - Trial subtract of the upper partial remainder (WIDTH+1 bits) minus divisor.
  - Borrow -> shift left with quotient bit 0.
  - No borrow -> replace partial remainder with the difference and shift in quotient bit 1.
  - After WIDTH iterations -> FIX.
- FIX: one cycle.
  - Negate quotient if the quotient sign is set.
  - Negate remainder if the remainder sign is set; remainder takes the dividend's sign.
  - ovf_o=1 if signed_div_i=1, op1=100..0 and op2=all ones. The result is then quotient=op1 (wrapped), remainder=0, with no special-casing needed.
  - -> END.
- END:
  - result_o and flags driven from the internal registers; ready_o=1.
  - Remain in END while start_i=1.
  - start_i=0 -> FREE, and in the same edge clear ready_o, result_o and the flags.
- annul_i=1 in FREE, DBZ, ON or FIX -> FREE next edge, ready_o stays 0.
- annul_i is ignored in END.
- Latency, with start sampled at edge E0 and optional feature off:
  - normal: ready_o rises at E0+WIDTH+2;
  - divide-by-zero: ready_o rises at E0+2.
- A new start is accepted only in FREE, so there is at least one idle cycle between operations.
- Width rules:
  - Absolute value of MIN stays MIN, treated as an unsigned magnitude.
  - All negation is two's-complement, truncated to WIDTH bits.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - On entry to ON, compute lz = leading zeros of |op1|.
  - Pre-shift the dividend left by lz.
  - Set the counter start to lz, so ON runs WIDTH-lz iterations, with a minimum of 1 (|op1|=0 runs 1 iteration).
  - Normal latency becomes E0+(WIDTH-lz)+2; results are identical to the feature-off build.
- Undefined: fixed WIDTH iterations, and no leading-zero logic is synthesised.

Test Plan (WIDTH=32):
1. Unsigned 100/7 -> quotient 0x0000000E, remainder 0x00000002; ready_o at E0+34; dbz_o=0, ovf_o=0.
2. Signed -100 (0xFFFFFF9C) / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Signed 100 / -7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
3. Divide 0x12345678 by 0 -> quotient 0xFFFFFFFF, remainder 0x12345678, dbz_o=1, ready_o at E0+2.
4. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, ovf_o=1. Unsigned with the same operands -> quotient 0, remainder 0x80000000, ovf_o=0.
5. Abort and reset:
   - annul_i pulsed at cycle 10 of ON -> FREE, ready_o never rises; a following 9/3 gives quotient 3, remainder 0.
   - rst driven low mid-ON -> all outputs 0 immediately, without waiting for a clock edge.
6. Result hold, and early-out if the macro is defined:
   - start_i held high after ready_o -> result held until start_i drops, then cleared next edge.
   - With DIV_EARLY_OUT_EN: unsigned 5/2 -> quotient 2, remainder 1, ready_o at E0+5 (lz=29).
